// File: rtl/rvfi_trace_streamer.sv
// Purpose: queue retired-instruction records and serialise each as a 14-byte trace frame.
// Latency: a record sampled at edge E0 is popped at E1; byte 0 is valid after E1.
// Backpressure: out_data/out_valid hold while out_ready=0; records arriving to a full queue are dropped and counted.
module rvfi_trace_streamer #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     cpu_clk,
   input  logic                     reset,
   input  logic                     trace_en,
   input  logic                     rvfi_valid,
   input  logic [31:0]              rvfi_insn,
   input  logic [31:0]              rvfi_pc_rdata,
   input  logic [4:0]               rvfi_rd_addr,
   input  logic [31:0]              rvfi_rd_wdata,
   input  logic                     drop_clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, SEND} state_t;

   typedef struct packed {
      logic        mark;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } rec_t;

   rec_t             mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   state_t           state_q, state_d;
   rec_t             frame_q, frame_d;
   logic [3:0]       byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;
   logic             pending_q, pending_d;

   logic             accept, push, drop, pop, xfer;
   rec_t             in_rec;
   logic [7:0]       byte_sel;

   // Capture, drop accounting, queue bookkeeping and frame sequencing.
   always_comb begin
      accept       = rvfi_valid & trace_en;
      // Fullness is judged on the registered level: a same-cycle pop frees nothing.
      push         = accept & (level_q != FULL_LVL);
      drop         = accept & (level_q == FULL_LVL);
      xfer         = (state_q == SEND) & out_ready;
      in_rec       = '{mark: pending_q, pc: rvfi_pc_rdata, insn: rvfi_insn,
                       wdata: rvfi_rd_wdata, rd: rvfi_rd_addr};

      pop          = 1'b0;
      state_d      = state_q;
      frame_d      = frame_q;
      byte_idx_d   = byte_idx_q;

      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop        = 1'b1;
               frame_d    = mem_q[rd_ptr_q];
               byte_idx_d = 4'd0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (byte_idx_q != 4'd13) begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end else if (level_q != '0) begin
                  pop        = 1'b1;
                  frame_d    = mem_q[rd_ptr_q];
                  byte_idx_d = 4'd0;
               end else begin
                  byte_idx_d = 4'd0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);

      // A drop in the same cycle as a clear still registers as one drop.
      drop_cnt_d = drop_cnt_q;
      if (drop_clr) begin
         drop_cnt_d = drop ? CNT_W'(1) : '0;
      end else if (drop && (drop_cnt_q != CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      overflow_d = drop_clr ? drop : (overflow_q | drop);

      // The mark travels with the first record accepted after any drop.
      pending_d = pending_q;
      if (push) begin
         pending_d = 1'b0;
      end else if (drop) begin
         pending_d = 1'b1;
      end
   end

   // Byte selection for the frame currently being sent, multi-byte fields LSB first.
   always_comb begin
      byte_sel = 8'h00;
      case (byte_idx_q)
         4'd0:    byte_sel = frame_q.mark ? 8'hA7 : 8'hA5;
         4'd1:    byte_sel = frame_q.pc[7:0];
         4'd2:    byte_sel = frame_q.pc[15:8];
         4'd3:    byte_sel = frame_q.pc[23:16];
         4'd4:    byte_sel = frame_q.pc[31:24];
         4'd5:    byte_sel = frame_q.insn[7:0];
         4'd6:    byte_sel = frame_q.insn[15:8];
         4'd7:    byte_sel = frame_q.insn[23:16];
         4'd8:    byte_sel = frame_q.insn[31:24];
         4'd9:    byte_sel = frame_q.wdata[7:0];
         4'd10:   byte_sel = frame_q.wdata[15:8];
         4'd11:   byte_sel = frame_q.wdata[23:16];
         4'd12:   byte_sel = frame_q.wdata[31:24];
         4'd13:   byte_sel = {3'b000, frame_q.rd};
         default: byte_sel = 8'h00;
      endcase
   end

   // Record storage; contents are don't-care until written, so no reset.
   always_ff @(posedge cpu_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_rec;
      end
   end

   // Control state; reset abandons any frame in flight.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= IDLE;
         frame_q    <= '0;
         byte_idx_q <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         state_q    <= state_d;
         frame_q    <= frame_d;
         byte_idx_q <= byte_idx_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
         pending_q  <= pending_d;
      end
   end

   assign out_valid  = (state_q == SEND);
   assign out_data   = (state_q == SEND) ? byte_sel : 8'h00;
   assign fifo_level = level_q;
   assign drop_cnt   = drop_cnt_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_rvfi_trace_streamer.sv
// Purpose: directed checks of rvfi_trace_streamer framing, backpressure, drops and reset.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: out_ready toggled by the directed steps below.
module tb_rvfi_trace_streamer;

   logic        cpu_clk = 1'b0;
   logic        reset;
   logic        trace_en;
   logic        rvfi_valid;
   logic [31:0] rvfi_insn;
   logic [31:0] rvfi_pc_rdata;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic        drop_clr;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  fifo_level;
   logic [15:0] drop_cnt;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   rvfi_trace_streamer #(.DEPTH(8), .CNT_W(16)) dut (
      .cpu_clk       (cpu_clk),
      .reset         (reset),
      .trace_en      (trace_en),
      .rvfi_valid    (rvfi_valid),
      .rvfi_insn     (rvfi_insn),
      .rvfi_pc_rdata (rvfi_pc_rdata),
      .rvfi_rd_addr  (rvfi_rd_addr),
      .rvfi_rd_wdata (rvfi_rd_wdata),
      .drop_clr      (drop_clr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .fifo_level    (fifo_level),
      .drop_cnt      (drop_cnt),
      .overflow      (overflow)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected frame, byte 0 in the least significant byte.
   function automatic logic [111:0] mk(input logic m, input logic [31:0] pc, input logic [31:0] insn,
                                       input logic [31:0] wd, input logic [4:0] rd);
      return {3'b000, rd, wd, insn, pc, (m ? 8'hA7 : 8'hA5)};
   endfunction

   function automatic logic [31:0] pc_of(input int k);   return 32'h0000_1000 + 32'(4 * k); endfunction
   function automatic logic [31:0] insn_of(input int k); return 32'h0000_0013 + 32'(k << 20); endfunction
   function automatic logic [31:0] wd_of(input int k);   return 32'hC0DE_0000 + 32'(k); endfunction
   function automatic logic [4:0]  rd_of(input int k);   return 5'(k); endfunction

   function automatic logic [111:0] mk_k(input logic m, input int k);
      return mk(m, pc_of(k), insn_of(k), wd_of(k), rd_of(k));
   endfunction

   task automatic push_rec(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] wd,
                           input logic [4:0] rd);
      rvfi_pc_rdata = pc;
      rvfi_insn     = insn;
      rvfi_rd_wdata = wd;
      rvfi_rd_addr  = rd;
      rvfi_valid    = 1'b1;
      step();
      rvfi_valid    = 1'b0;
   endtask

   task automatic push_k(input int k);
      push_rec(pc_of(k), insn_of(k), wd_of(k), rd_of(k));
   endtask

   // Waits (bounded) for out_valid, then takes 14 bytes with out_ready held high.
   task automatic collect(input string tag, input logic [111:0] exp, output int waited);
      logic [111:0] got;
      int           gaps;
      waited = 0;
      while (!out_valid && waited < 30) begin
         step();
         waited++;
      end
      got  = '0;
      gaps = 0;
      for (int i = 0; i < 14; i++) begin
         if (!out_valid) gaps++;
         got[8*i +: 8] = out_data;
         step();
      end
      chk(tag, 128'(got), 128'(exp));
      chk({tag, "_gaps"}, 128'(gaps), 128'(0));
   endtask

   initial begin
      logic [111:0] exp_f;
      logic [111:0] got;
      int           w;
      int           xfers;
      int           cyc;

      reset = 1'b1; trace_en = 1'b1; rvfi_valid = 1'b0; rvfi_insn = '0; rvfi_pc_rdata = '0;
      rvfi_rd_addr = '0; rvfi_rd_wdata = '0; drop_clr = 1'b0; out_ready = 1'b1;
      step();
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_data", 128'(out_data), 128'(0));
      chk("rst_level", 128'(fifo_level), 128'(0));
      chk("rst_drop", 128'(drop_cnt), 128'(0));
      chk("rst_ovf", 128'(overflow), 128'(0));
      reset = 1'b0;
      step();

      // Single record: byte 0 valid two edges after the strobe.
      push_rec(32'h0000_0010, 32'h00A0_0093, 32'h0000_000A, 5'd1);
      chk("single_lvl_e0", 128'(fifo_level), 128'(1));
      chk("single_valid_e0", 128'(out_valid), 128'(0));
      step();
      chk("single_valid_e1", 128'(out_valid), 128'(1));
      chk("single_hdr_e1", 128'(out_data), 128'(8'hA5));
      chk("single_lvl_e1", 128'(fifo_level), 128'(0));
      collect("single_frame", 112'h0100_0000_0A00_A000_9300_0000_10A5, w);
      chk("single_wait", 128'(w), 128'(0));
      chk("single_idle", 128'(out_valid), 128'(0));

      // Backpressure: stall 5 cycles with byte 3 on the bus.
      exp_f = mk(1'b0, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 5'd31);
      push_rec(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 5'd31);
      step();
      got   = '0;
      xfers = 0;
      for (cyc = 0; cyc < 40 && xfers < 14; cyc++) begin
         out_ready = (cyc < 3) || (cyc >= 8);
         if (cyc >= 3 && cyc < 8) begin
            chk("bp_hold_data", 128'(out_data), 128'(8'h22));
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
         end
         if (out_valid && out_ready) begin
            got[8*xfers +: 8] = out_data;
            xfers++;
         end
         step();
      end
      chk("bp_frame", 128'(got), 128'(exp_f));
      chk("bp_xfers", 128'(xfers), 128'(14));
      chk("bp_idle", 128'(out_valid), 128'(0));

      // Back-to-back: three frames queued, then 42 transfers with no gap.
      out_ready = 1'b0;
      push_k(40); push_k(41); push_k(42);
      chk("b2b_lvl", 128'(fifo_level), 128'(2));
      out_ready = 1'b1;
      collect("b2b_f0", mk_k(1'b0, 40), w);
      chk("b2b_w0", 128'(w), 128'(0));
      collect("b2b_f1", mk_k(1'b0, 41), w);
      chk("b2b_w1", 128'(w), 128'(0));
      collect("b2b_f2", mk_k(1'b0, 42), w);
      chk("b2b_w2", 128'(w), 128'(0));
      chk("b2b_lvl_end", 128'(fifo_level), 128'(0));
      chk("b2b_idle", 128'(out_valid), 128'(0));

      // Overflow: 10 records with the sink stalled; record 1 sits in the frame, 2..9 fill, 10 drops.
      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) push_k(k);
      chk("ovf_lvl", 128'(fifo_level), 128'(8));
      chk("ovf_cnt", 128'(drop_cnt), 128'(1));
      chk("ovf_flag", 128'(overflow), 128'(1));
      out_ready = 1'b1;
      collect("ovf_f1", mk_k(1'b0, 1), w);
      out_ready = 1'b0;
      push_k(11);
      chk("ovf_lvl_refill", 128'(fifo_level), 128'(8));
      chk("ovf_cnt_hold", 128'(drop_cnt), 128'(1));
      out_ready = 1'b1;
      for (int k = 2; k <= 9; k++) collect("ovf_fk", mk_k(1'b0, k), w);
      collect("ovf_marked", mk_k(1'b1, 11), w);
      chk("ovf_drained", 128'(fifo_level), 128'(0));

      // drop_clr coincident with a drop, then alone.
      out_ready = 1'b0;
      for (int k = 1; k <= 9; k++) push_k(k);
      drop_clr = 1'b1;
      push_k(10);
      chk("clr_drop_cnt", 128'(drop_cnt), 128'(1));
      chk("clr_drop_ovf", 128'(overflow), 128'(1));
      step();
      drop_clr = 1'b0;
      chk("clr_cnt", 128'(drop_cnt), 128'(0));
      chk("clr_ovf", 128'(overflow), 128'(0));

      out_ready = 1'b1;
      w = 0;
      while ((out_valid || fifo_level != 0) && w < 300) begin
         step();
         w++;
      end
      chk("drain_timeout", 128'(w < 300), 128'(1));

      // Reset at byte 7 with two records queued; the pending mark survived drop_clr.
      out_ready = 1'b0;
      push_k(20); push_k(21); push_k(22);
      chk("rstm_hdr_marked", 128'(out_data), 128'(8'hA7));
      out_ready = 1'b1;
      repeat (7) step();
      exp_f = mk_k(1'b1, 20);
      chk("rstm_byte7", 128'(out_data), 128'(exp_f[63:56]));
      chk("rstm_lvl_pre", 128'(fifo_level), 128'(2));
      #3;
      reset = 1'b1;
      #1;
      chk("rstm_valid", 128'(out_valid), 128'(0));
      chk("rstm_lvl", 128'(fifo_level), 128'(0));
      chk("rstm_data", 128'(out_data), 128'(0));
      step();
      reset = 1'b0;
      step();
      chk("rstm_idle", 128'(out_valid), 128'(0));
      push_k(30);
      collect("rstm_fresh", mk_k(1'b0, 30), w);

      // trace_en low: strobes ignored and not counted.
      trace_en = 1'b0;
      push_k(31);
      step();
      chk("ten_lvl", 128'(fifo_level), 128'(0));
      chk("ten_valid", 128'(out_valid), 128'(0));
      chk("ten_drop", 128'(drop_cnt), 128'(0));
      trace_en = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
